imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, parametrised immediate generator for the decode stage of the pipelined RISC-V core. It classifies each incoming instruction into R/I/S/B/U/J format and produces the sign-extended XLEN-bit immediate; shift-immediate forms produce a zero-extended shamt. The block is one pipeline stage with valid/ready handshakes, a 2-entry skid buffer and a synchronous flush. It sits between the instruction-fetch register and the register-read / ALU operand mux.

## Interface
- `XLEN`, 64, datapath width; legal values are 32 and 64.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline kill; drops all held and incoming entries.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept; equals `!skid_valid`.
- `in_instr`  in  32  raw instruction word.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts.
- `out_instr`  out  32  instruction passed through unchanged.
- `out_imm`  out  XLEN  extended immediate.
- `out_fmt`  out  3  format code.
- `out_illegal`  out  1  unsupported opcode, or shamt out of range.

## Operation
- Decoding uses `in_instr[6:0]`. Sign bit is always `instr[31]`.
  - **I format:** opcodes 0000011, 0010011, 1100111, 1110011, and 0011011 (only when XLEN=64). Immediate = `sext(instr[31:20])`.
  - **Shift exception (I format):** opcode 0010011 or 0011011 with funct3 001/101 gives a zero-extended shamt:
    - `instr[25:20]` when XLEN=64 and opcode is 0010011;
    - `instr[24:20]` otherwise.
    - If XLEN=32, opcode 0010011 and `instr[25]=1`, set illegal.
  - **S format:** opcode 0100011. Immediate = `sext({instr[31:25], instr[11:7]})`.
  - **B format:** opcode 1100011. Immediate = `sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})`.
  - **U format:** opcodes 0110111, 0010111. Immediate = `sext({instr[31:12], 12'b0})`.
  - **J format:** opcode 1101111. Immediate = `sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})`.
  - **R format:** opcodes 0110011, and 0111011 when XLEN=64. Immediate = 0, not illegal.
  - **Anything else:** immediate = 0, fmt = ILL, `out_illegal=1`.
- Decode is combinational on the input. The decoded tuple (instr, imm, fmt, illegal) is what gets registered.
- Storage consists of the output register (`out_*`, `out_valid`) and one skid register (`skid_*`, `skid_valid`).
- An input is accepted when `in_valid && in_ready`.
- When `!out_valid || out_ready`:
  - if `skid_valid`: out ← skid, and `skid_valid` ← 0;
  - else: out ← decode(in), and `out_valid` ← accepted.
- When `out_valid && !out_ready` and an input is accepted: skid ← decode(in), and `skid_valid` ← 1.
- Ordering is strictly FIFO. No entry is ever dropped except by `flush` or `reset`.
- `flush` (non-reset cycle): `out_valid` and `skid_valid` ← 0. The input presented in that cycle is discarded, even if the handshake completes. Data registers hold their values.

## Timing
- Latency is 1 cycle: input accepted at edge N appears on `out_*` after edge N when the output register is free.
- Sustained throughput is 1 instruction per cycle while `out_ready=1`.
- Under a stall, a second instruction lands in the skid register. `in_ready` falls the cycle after the skid fills and rises the cycle after the skid drains.
- Reset values:
  - `out_valid=0`, `skid_valid=0`, `in_ready=1`;
  - `out_imm=0`, `out_fmt=R(0)`, `out_illegal=0`, `out_instr=0x00000013` (NOP).
- `reset` has priority over `flush`. Either one mid-stall empties the stage in one cycle.
- `out_*` is stable while `out_valid && !out_ready`.
- `flush` and `out_ready` asserted in the same cycle: the flush wins, and nothing is re-presented.

## Structure
- Package `imm_pkg` holds:
  - format codes: `FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_ILL=7`;
  - opcode constants;
  - the NOP constant;
  - a packed struct `imm_result_t` {instr, imm, fmt, illegal}.
- Sub-module `imm_decode` is purely combinational: instr → `imm_result_t`, parametrised by XLEN. The top level instantiates it once and holds the skid/output registers and the handshake.

## Test plan
- **I format, all-ones:** 0xFFF00093 (addi x1,x0,-1), XLEN=64 → next cycle `out_imm`=0xFFFFFFFFFFFFFFFF, fmt=1, illegal=0.
- **S and B formats, back-to-back with `out_ready=1`:**
  - 0xFE112E23 (sw x1,-4(x2)) → imm=-4, fmt=2;
  - then 0xFE000CE3 (beq -8) → imm=-8, fmt=3.
- **U format and shift:**
  - 0x800002B7 (lui) → 0xFFFFFFFF80000000;
  - 0x43F0D093 (srai x1,x1,63) → 0x3F.
  - With XLEN=32, the same srai → illegal=1.
- **Backpressure:** hold `out_ready=0`, send A and B.
  - `in_ready`=0 after B is accepted.
  - Release `out_ready`: A then B on consecutive cycles, `in_ready` back to 1.
- **Flush:** assert `flush` with output and skid full and `in_valid=1` → next cycle `out_valid=0`, `skid_valid=0`, `in_ready=1`; no stale output afterwards.
- **Illegal and reset:**
  - opcode 0x7F → fmt=7, imm=0, illegal=1.
  - Reset mid-stall → all reset values hold the following cycle.

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// Shared types and constants for the RISC-V immediate-generation stage:
// format codes, base opcodes, the NOP word and the decoded-result record.
package imm_pkg;

  // Immediates are always built at the widest legal XLEN and narrowed by the consumer.
  localparam int IMM_W = 64;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]      instr;
    logic [IMM_W-1:0] imm;
    fmt_e             fmt;
    logic             illegal;
  } imm_result_t;

  localparam imm_result_t RESET_RESULT = '{
    instr:   NOP_INSTR,
    imm:     {IMM_W{1'b0}},
    fmt:     FMT_R,
    illegal: 1'b0
  };

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational instruction classifier and immediate extractor.
// Produces a 64-bit sign-extended immediate; narrower datapaths keep the low XLEN bits.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]  instr,
  output imm_result_t  result
);

  logic [6:0]       opcode_s;
  logic [2:0]       funct3_s;
  logic             sign_s;
  logic [IMM_W-1:0] imm_i_s;
  logic [IMM_W-1:0] imm_s_s;
  logic [IMM_W-1:0] imm_b_s;
  logic [IMM_W-1:0] imm_u_s;
  logic [IMM_W-1:0] imm_j_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign sign_s   = instr[31];

  assign imm_i_s = {{52{sign_s}}, instr[31:20]};
  assign imm_s_s = {{52{sign_s}}, instr[31:25], instr[11:7]};
  assign imm_b_s = {{51{sign_s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u_s = {{32{sign_s}}, instr[31:12], 12'h000};
  assign imm_j_s = {{43{sign_s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode classification; unknown opcodes fall through to the illegal defaults.
  always_comb begin
    result.instr   = instr;
    result.imm     = {IMM_W{1'b0}};
    result.fmt     = FMT_ILL;
    result.illegal = 1'b1;
    case (opcode_s)
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        result.fmt     = FMT_I;
        result.illegal = 1'b0;
        result.imm     = imm_i_s;
      end
      OP_IMM: begin
        result.fmt     = FMT_I;
        result.illegal = 1'b0;
        result.imm     = imm_i_s;
        if (is_shift(funct3_s)) begin
          if (XLEN == 64) begin
            result.imm = {58'd0, instr[25:20]};
          end else begin
            // A 6-bit shamt cannot address a 32-bit register.
            result.imm     = {59'd0, instr[24:20]};
            result.illegal = instr[25];
          end
        end else begin
          result.imm = imm_i_s;
        end
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          result.fmt     = FMT_I;
          result.illegal = 1'b0;
          if (is_shift(funct3_s)) begin
            result.imm = {59'd0, instr[24:20]};
          end else begin
            result.imm = imm_i_s;
          end
        end else begin
          result.fmt     = FMT_ILL;
          result.illegal = 1'b1;
          result.imm     = {IMM_W{1'b0}};
        end
      end
      OP_STORE: begin
        result.fmt     = FMT_S;
        result.illegal = 1'b0;
        result.imm     = imm_s_s;
      end
      OP_BRANCH: begin
        result.fmt     = FMT_B;
        result.illegal = 1'b0;
        result.imm     = imm_b_s;
      end
      OP_LUI, OP_AUIPC: begin
        result.fmt     = FMT_U;
        result.illegal = 1'b0;
        result.imm     = imm_u_s;
      end
      OP_JAL: begin
        result.fmt     = FMT_J;
        result.illegal = 1'b0;
        result.imm     = imm_j_s;
      end
      OP_OP: begin
        result.fmt     = FMT_R;
        result.illegal = 1'b0;
        result.imm     = {IMM_W{1'b0}};
      end
      OP_OP_32: begin
        if (XLEN == 64) begin
          result.fmt     = FMT_R;
          result.illegal = 1'b0;
        end else begin
          result.fmt     = FMT_ILL;
          result.illegal = 1'b1;
        end
        result.imm = {IMM_W{1'b0}};
      end
      default: begin
        result.fmt     = FMT_ILL;
        result.illegal = 1'b1;
        result.imm     = {IMM_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: one registered pipeline stage with a
// valid/ready handshake, a single skid entry and a synchronous flush.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  imm_result_t dec_s;
  imm_result_t out_r;
  imm_result_t skid_r;
  logic        out_valid_r;
  logic        skid_valid_r;
  logic        accept_s;
  logic        out_free_s;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr  (in_instr),
    .result (dec_s)
  );

  assign in_ready   = !skid_valid_r;
  assign accept_s   = in_valid && !skid_valid_r;
  assign out_free_s = !out_valid_r || out_ready;

  // Output/skid storage; the skid always drains before new input reaches the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r        <= RESET_RESULT;
      skid_r       <= RESET_RESULT;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        out_r        <= skid_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else begin
        if (accept_s) begin
          out_r <= dec_s;
        end else begin
          out_r <= out_r;
        end
        out_valid_r <= accept_s;
      end
    end else if (accept_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_instr   = out_r.instr;
  assign out_imm     = out_r.imm[XLEN-1:0];
  assign out_fmt     = out_r.fmt;
  assign out_illegal = out_r.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: an XLEN=64 and an XLEN=32 instance share stimulus.
module tb_imm_gen_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] out_instr32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        out_illegal32;

  int checks;
  int errors;

  imm_gen_stage #(.XLEN(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal)
  );

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready32),
    .in_instr    (in_instr),
    .out_valid   (out_valid32),
    .out_ready   (out_ready),
    .out_instr   (out_instr32),
    .out_imm     (out_imm32),
    .out_fmt     (out_fmt32),
    .out_illegal (out_illegal32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_imm"}, out_imm, 64'd0);
    chk({tag, "_fmt"}, {61'd0, out_fmt}, 64'd0);
    chk({tag, "_illegal"}, {63'd0, out_illegal}, 64'd0);
    chk({tag, "_instr"}, {32'd0, out_instr}, 64'h0000_0000_0000_0013);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] instr, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic ill);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_instr"}, {32'd0, out_instr}, {32'd0, instr});
    chk({tag, "_imm"}, out_imm, imm);
    chk({tag, "_fmt"}, {61'd0, out_fmt}, {61'd0, fmt});
    chk({tag, "_illegal"}, {63'd0, out_illegal}, {63'd0, ill});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0000_0000;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_reset_state("reset");

    // Streaming decode with out_ready held high
    in_valid = 1'b1;
    in_instr = 32'hFFF0_0093;
    step();
    chk_out("addi", 32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    in_instr = 32'hFE11_2E23;
    step();
    chk_out("sw", 32'hFE11_2E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    in_instr = 32'hFE00_0CE3;
    step();
    chk_out("beq", 32'hFE00_0CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);
    in_instr = 32'h8000_02B7;
    step();
    chk_out("lui", 32'h8000_02B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    in_instr = 32'h43F0_D093;
    step();
    chk_out("srai", 32'h43F0_D093, 64'h0000_0000_0000_003F, 3'd1, 1'b0);
    chk("srai32_illegal", {63'd0, out_illegal32}, 64'd1);
    chk("srai32_imm", {32'd0, out_imm32}, 64'h0000_0000_0000_001F);
    in_instr = 32'hFFDF_F06F;
    step();
    chk_out("jal", 32'hFFDF_F06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0);
    in_instr = 32'h0020_81B3;
    step();
    chk_out("add", 32'h0020_81B3, 64'd0, 3'd0, 1'b0);
    in_instr = 32'h0000_007F;
    step();
    chk_out("ill", 32'h0000_007F, 64'd0, 3'd7, 1'b1);
    in_valid = 1'b0;
    step();
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: A in output, B in skid, then drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF0_0093;
    step();
    chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
    in_instr = 32'hFE11_2E23;
    step();
    chk("bp_b_ready", {63'd0, in_ready}, 64'd0);
    chk_out("bp_hold_a", 32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    in_valid = 1'b0;
    step();
    chk_out("bp_stable_a", 32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    out_ready = 1'b1;
    step();
    chk_out("bp_drain_b", 32'hFE11_2E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
    step();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Flush with both entries full and a live input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF0_0093;
    step();
    in_instr = 32'hFE11_2E23;
    step();
    chk("fl_full", {63'd0, in_ready}, 64'd0);
    in_instr  = 32'h8000_02B7;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("fl_no_stale", {63'd0, out_valid}, 64'd0);
    step();
    chk("fl_no_stale2", {63'd0, out_valid}, 64'd0);

    // Reset mid-stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFE00_0CE3;
    step();
    in_instr = 32'h0000_007F;
    step();
    chk("rs_full", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    flush = 1'b1;
    step();
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_reset_state("midreset");
    out_ready = 1'b1;
    step();
    chk("rs_empty", {63'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
